// File: rtl/caption_pkg.sv
// Shared constants, FSM state encoding and code substitution for the caption line renderer.
// The optional CAPTION_PIXEL_DOUBLE_EN build macro is consumed by glyph_shifter.
package caption_pkg;

   localparam int FONT_ADDR_W = 11;
   localparam int GLYPH_W = 8;
   localparam int GLYPH_H = 8;
   localparam logic [7:0] SUBST_CHAR = 8'h3F;

   typedef enum logic [2:0] {
      IDLE,
      TXT_RD,
      TXT_WAIT,
      FONT_RD,
      FONT_WAIT,
      SHIFT,
      DONE
   } state_t;

   // Codes outside 7-bit ASCII have no glyph, so they render as '?'.
   function automatic logic [7:0] subst_code(input logic [7:0] code);
      return code[7] ? SUBST_CHAR : code;
   endfunction

endpackage

// File: rtl/glyph_shifter.sv
// MSB-first serializer for one glyph row with valid/ready and a bit counter.
// With CAPTION_PIXEL_DOUBLE_EN defined, each pixel is emitted twice for 2x horizontal scaling.
module glyph_shifter
   import caption_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic [GLYPH_W-1:0] load_data,
   input  logic               active,
   input  logic               ready,
   input  logic               last_char,
   output logic               valid,
   output logic               pix_on,
   output logic               last,
   output logic               last_hs
);

   logic [GLYPH_W-1:0] shift;
   logic [2:0]         bit_cnt;
   logic               hs;
   logic               step;

   assign valid  = active;
   assign pix_on = active & shift[GLYPH_W-1];
   assign hs     = active & ready;

`ifdef CAPTION_PIXEL_DOUBLE_EN
   logic sub;

   // The shift only advances once both copies of the current pixel are accepted.
   assign step    = hs & sub;
   assign last    = active & last_char & (bit_cnt == 3'd0) & sub;
   assign last_hs = hs & (bit_cnt == 3'd0) & sub;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sub <= 1'b0;
      end else if (load) begin
         sub <= 1'b0;
      end else if (hs) begin
         sub <= ~sub;
      end
   end
`else
   assign step    = hs;
   assign last    = active & last_char & (bit_cnt == 3'd0);
   assign last_hs = hs & (bit_cnt == 3'd0);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift   <= '0;
         bit_cnt <= 3'd0;
      end else if (load) begin
         shift   <= load_data;
         bit_cnt <= 3'd7;
      end else if (step) begin
         shift   <= {shift[GLYPH_W-2:0], 1'b0};
         bit_cnt <= bit_cnt - 3'd1;
      end
   end

endmodule

// File: rtl/caption_line_renderer.sv
// Fetches each caption character and its font row, then streams the row as 1bpp pixels.
// Build macro CAPTION_PIXEL_DOUBLE_EN (handled in glyph_shifter) doubles every pixel.
module caption_line_renderer
   import caption_pkg::*;
#(
   parameter int MAX_CHARS = 30,
   parameter int TEXT_AW   = $clog2(MAX_CHARS),
   parameter int CNT_W     = $clog2(MAX_CHARS + 1)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [$clog2(GLYPH_H)-1:0] row,
   input  logic [CNT_W-1:0]           num_chars,
   output logic                       busy,
   output logic                       done,
   output logic                       text_rd,
   output logic [TEXT_AW-1:0]         text_addr,
   input  logic [7:0]                 text_data,
   output logic [FONT_ADDR_W-1:0]     font_addr,
   input  logic [GLYPH_W-1:0]         font_data,
   output logic                       pix_valid,
   input  logic                       pix_ready,
   output logic                       pix_on,
   output logic                       pix_last
);

   state_t                     state;
   state_t                     next_state;
   logic [CNT_W-1:0]           idx;
   logic [CNT_W-1:0]           num_l;
   logic [CNT_W-1:0]           num_clamped;
   logic [$clog2(GLYPH_H)-1:0] row_l;
   logic [FONT_ADDR_W-1:0]     font_addr_r;
   logic                       last_char;
   logic                       last_hs;

   assign num_clamped = (num_chars > CNT_W'(MAX_CHARS)) ? CNT_W'(MAX_CHARS) : num_chars;
   assign last_char   = (idx == num_l - CNT_W'(1));

   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign text_rd   = (state == TXT_RD);
   assign text_addr = idx[TEXT_AW-1:0];
   assign font_addr = font_addr_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // The font address is formed as the text byte arrives so the ROM sees it throughout FONT_RD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx         <= '0;
         num_l       <= '0;
         row_l       <= '0;
         font_addr_r <= '0;
      end else begin
         if (state == IDLE && start) begin
            idx   <= '0;
            num_l <= num_clamped;
            row_l <= row;
         end
         if (state == TXT_WAIT) begin
            font_addr_r <= {subst_code(text_data), row_l};
         end
         if (state == SHIFT && last_hs && !last_char) begin
            idx <= idx + CNT_W'(1);
         end
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:      if (start) next_state = (num_chars == '0) ? DONE : TXT_RD;
         TXT_RD:    next_state = TXT_WAIT;
         TXT_WAIT:  next_state = FONT_RD;
         FONT_RD:   next_state = FONT_WAIT;
         FONT_WAIT: next_state = SHIFT;
         SHIFT:     if (last_hs) next_state = last_char ? DONE : TXT_RD;
         DONE:      next_state = IDLE;
         default:   next_state = IDLE;
      endcase
   end

   glyph_shifter u_shifter (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (state == FONT_WAIT),
      .load_data (font_data),
      .active    (state == SHIFT),
      .ready     (pix_ready),
      .last_char (last_char),
      .valid     (pix_valid),
      .pix_on    (pix_on),
      .last      (pix_last),
      .last_hs   (last_hs)
   );

endmodule

// File: tb/tb_caption_line_renderer.sv
// Directed self-checking bench for caption_line_renderer with text buffer and font ROM models.
// Expectations follow CAPTION_PIXEL_DOUBLE_EN when the bench is built with it.
module tb_caption_line_renderer;

`ifdef CAPTION_PIXEL_DOUBLE_EN
   localparam int PPC = 16;
`else
   localparam int PPC = 8;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [2:0]  row;
   logic [4:0]  num_chars;
   logic        busy;
   logic        done;
   logic        text_rd;
   logic [4:0]  text_addr;
   logic [7:0]  text_data;
   logic [10:0] font_addr;
   logic [7:0]  font_data;
   logic        pix_valid;
   logic        pix_ready;
   logic        pix_on;
   logic        pix_last;

   logic [7:0]  text_mem [0:31];

   int compared = 0;
   int mismatched = 0;

   int          run_pix_count;
   logic [31:0] run_word;
   int          run_last_count;
   int          run_last_idx;
   int          run_first_valid;
   int          run_done_at;
   int          run_text_reads;
   logic [10:0] run_fa [0:1];
   int          run_fa_count;

   caption_line_renderer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .row       (row),
      .num_chars (num_chars),
      .busy      (busy),
      .done      (done),
      .text_rd   (text_rd),
      .text_addr (text_addr),
      .text_data (text_data),
      .font_addr (font_addr),
      .font_data (font_data),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .pix_on    (pix_on),
      .pix_last  (pix_last)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] font_rom(input logic [10:0] a);
      case (a)
         11'h208: return 8'h10;
         11'h243: return 8'hFE;
         11'h34B: return 8'h30;
         11'h1FA: return 8'h3C;
         default: return 8'h81;
      endcase
   endfunction

   function automatic logic [15:0] dbl(input logic [7:0] b);
      logic [15:0] r;
      for (int i = 0; i < 8; i++) begin
         r[2*i]   = b[i];
         r[2*i+1] = b[i];
      end
      return r;
   endfunction

   function automatic logic [31:0] exp_word1(input logic [7:0] b);
`ifdef CAPTION_PIXEL_DOUBLE_EN
      return {16'h0, dbl(b)};
`else
      return {24'h0, b};
`endif
   endfunction

   function automatic logic [31:0] exp_word2(input logic [7:0] b1, input logic [7:0] b2);
`ifdef CAPTION_PIXEL_DOUBLE_EN
      return {dbl(b1), dbl(b2)};
`else
      return {16'h0, b1, b2};
`endif
   endfunction

   always @(posedge clk) begin
      if (text_rd) text_data <= text_mem[text_addr];
      font_data <= font_rom(font_addr);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Pulse start through one clock edge; afterwards k=0 is the first sample after acceptance.
   task automatic applyStimulus(input logic [2:0] r, input logic [4:0] n);
      start     = 1'b1;
      row       = r;
      num_chars = n;
      tick();
      start = 1'b0;
   endtask

   task automatic runLine(input int max_cycles, input bit rnd, input int mid_start_at);
      logic       prev_stall;
      logic [2:0] held;
      logic       prev_valid;
      run_pix_count   = 0;
      run_word        = '0;
      run_last_count  = 0;
      run_last_idx    = -1;
      run_first_valid = -1;
      run_done_at     = -1;
      run_text_reads  = 0;
      run_fa_count    = 0;
      run_fa[0]       = '0;
      run_fa[1]       = '0;
      prev_stall      = 1'b0;
      prev_valid      = 1'b0;
      held            = '0;
      for (int k = 0; k < max_cycles; k++) begin
         if (text_rd) run_text_reads++;
         if (pix_valid && !prev_valid) begin
            if (run_fa_count < 2) run_fa[run_fa_count] = font_addr;
            run_fa_count++;
         end
         if (pix_valid && run_first_valid < 0) run_first_valid = k;
         if (prev_stall) checkOutput("stall_hold", {29'h0, pix_valid, pix_on, pix_last}, {29'h0, held});
         if (done) begin
            run_done_at = k;
            break;
         end
         prev_valid = pix_valid;
         start      = (k == mid_start_at);
         pix_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (pix_valid && pix_ready) begin
            run_word = {run_word[30:0], pix_on};
            if (pix_last) begin
               run_last_count++;
               run_last_idx = run_pix_count;
            end
            run_pix_count++;
         end
         prev_stall = pix_valid && !pix_ready;
         held       = {pix_valid, pix_on, pix_last};
         tick();
      end
      start     = 1'b0;
      pix_ready = 1'b1;
      tick();
      checkOutput("done_one_cycle", {31'h0, done}, 32'h0);
      checkOutput("busy_after_done", {31'h0, busy}, 32'h0);
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      row       = '0;
      num_chars = '0;
      pix_ready = 1'b0;
      for (int i = 0; i < 32; i++) text_mem[i] = 8'h41;
      repeat (3) tick();
      checkOutput("reset_outputs", {26'h0, busy, done, text_rd, pix_valid, pix_on, pix_last}, 32'h0);
      checkOutput("reset_font_addr", {21'h0, font_addr}, 32'h0);
      rst_n = 1'b1;
      tick();

      // Single 'A' at row 0, always ready
      $display("[TB] single character");
      text_mem[0] = 8'h41;
      applyStimulus(3'd0, 5'd1);
      checkOutput("busy_after_accept", {31'h0, busy}, 32'h1);
      runLine(200, 1'b0, -1);
      checkOutput("a_font_addr", {21'h0, run_fa[0]}, 32'h208);
      checkOutput("a_pixels", run_word, exp_word1(8'h10));
      checkOutput("a_pix_count", run_pix_count, PPC);
      checkOutput("a_last_count", run_last_count, 1);
      checkOutput("a_last_idx", run_last_idx, PPC - 1);
      checkOutput("a_first_valid", run_first_valid, 4);
      checkOutput("a_done_at", run_done_at, 4 + PPC);

      // Empty line
      $display("[TB] empty line");
      applyStimulus(3'd0, 5'd0);
      runLine(50, 1'b0, -1);
      checkOutput("empty_text_reads", run_text_reads, 0);
      checkOutput("empty_valid_seen", run_first_valid, -1);
      checkOutput("empty_done_at", run_done_at, 0);

      // "Hi" at row 3 with random backpressure
      $display("[TB] Hi with backpressure");
      text_mem[0] = 8'h48;
      text_mem[1] = 8'h69;
      applyStimulus(3'd3, 5'd2);
      runLine(400, 1'b1, -1);
      checkOutput("hi_font_addr0", {21'h0, run_fa[0]}, 32'h243);
      checkOutput("hi_font_addr1", {21'h0, run_fa[1]}, 32'h34B);
      checkOutput("hi_pixels", run_word, exp_word2(8'hFE, 8'h30));
      checkOutput("hi_pix_count", run_pix_count, 2 * PPC);
      checkOutput("hi_last_idx", run_last_idx, 2 * PPC - 1);
      checkOutput("hi_text_reads", run_text_reads, 2);

      // Non-ASCII code becomes '?'
      $display("[TB] substitution");
      text_mem[0] = 8'h9A;
      applyStimulus(3'd2, 5'd1);
      runLine(200, 1'b0, -1);
      checkOutput("subst_font_addr", {21'h0, run_fa[0]}, 32'h1FA);
      checkOutput("subst_pixels", run_word, exp_word1(8'h3C));

      // 31 is the largest count the 5-bit port carries; it must clamp to 30
      $display("[TB] clamp and ignored restart");
      for (int i = 0; i < 32; i++) text_mem[i] = 8'h41;
      applyStimulus(3'd1, 5'd31);
      runLine(2000, 1'b0, 50);
      checkOutput("clamp_text_reads", run_text_reads, 30);
      checkOutput("clamp_pix_count", run_pix_count, 30 * PPC);
      checkOutput("clamp_last_count", run_last_count, 1);
      checkOutput("clamp_last_idx", run_last_idx, 30 * PPC - 1);
      checkOutput("clamp_done_at", run_done_at, 30 * (4 + PPC));

      // Reset during the second character's pixels
      $display("[TB] reset mid-line");
      text_mem[0] = 8'h48;
      text_mem[1] = 8'h69;
      pix_ready = 1'b1;
      applyStimulus(3'd3, 5'd2);
      repeat (PPC + 10) tick();
      checkOutput("pre_reset_valid", {31'h0, pix_valid}, 32'h1);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_outputs", {26'h0, busy, done, text_rd, pix_valid, pix_on, pix_last}, 32'h0);
      checkOutput("abort_font_addr", {21'h0, font_addr}, 32'h0);
      tick();
      checkOutput("abort_no_done", {31'h0, done}, 32'h0);
      rst_n = 1'b1;
      tick();
      checkOutput("abort_idle", {31'h0, busy}, 32'h0);
      text_mem[0] = 8'h41;
      applyStimulus(3'd0, 5'd1);
      runLine(200, 1'b0, -1);
      checkOutput("restart_pixels", run_word, exp_word1(8'h10));
      checkOutput("restart_done_at", run_done_at, 4 + PPC);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
